// File: rtl/cmp_seq_ctrl.sv
// Wide-operand magnitude comparator sequencer: resolves A vs B one 2-bit digit pair
// per cycle, MSB digit first, between a valid/ready operand source and result sink.
module cmp_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1,
    localparam int DIGITS    = WIDTH / 2,
    localparam int CW        = $clog2(DIGITS + 1),
    localparam int IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic [CW-1:0]    digits_used,
    output logic [1:0]       o_dbg_state
);
    // Handshake rule: a transfer completes on a rising clk edge where valid, ready and
    // ena are all high; ready/valid are held low while ena is low so nothing transfers.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_RESULT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_used;
    logic             r_dec;
    logic             r_gt;
    logic [1:0]       w_da;
    logic [1:0]       w_db;
    logic             w_diff;
    logic             w_last;
    logic             w_done;
    logic             w_accept;

    assign w_da     = r_a[{r_idx, 1'b0} +: 2];
    assign w_db     = r_b[{r_idx, 1'b0} +: 2];
    assign w_diff   = (w_da != w_db);
    assign w_last   = (r_idx == '0);
    assign w_done   = (EARLY_EXIT && w_diff) || w_last;
    assign w_accept = ena && in_valid && (r_state == S_IDLE);

    assign digits_used = r_used;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        a_gt_b    = 1'b0;
        a_eq_b    = 1'b0;
        a_lt_b    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = ena;
                if (w_accept) w_next = S_COMPARE;
            end
            S_COMPARE: begin
                if (ena && w_done) w_next = S_RESULT;
            end
            S_RESULT: begin
                out_valid = ena;
                // Undecided after the last digit means every digit pair matched.
                a_gt_b    = r_dec & r_gt;
                a_lt_b    = r_dec & ~r_gt;
                a_eq_b    = ~r_dec;
                if (ena && out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_idx  <= IW'(DIGITS - 1);
            r_used <= '0;
            r_dec  <= 1'b0;
            r_gt   <= 1'b0;
        end else if (ena) begin
            if (w_accept) begin
                r_a    <= in_a;
                r_b    <= in_b;
                r_idx  <= IW'(DIGITS - 1);
                r_used <= '0;
                r_dec  <= 1'b0;
                r_gt   <= 1'b0;
            end else if (r_state == S_COMPARE) begin
                r_used <= r_used + CW'(1);
                // Only the most significant unequal digit decides the result.
                if (!r_dec && w_diff) begin
                    r_dec <= 1'b1;
                    r_gt  <= (w_da > w_db);
                end
                if (!w_done) r_idx <= r_idx - IW'(1);
            end
        end
    end
endmodule

// File: doc/cmp_seq_ctrl.md
Name: cmp_seq_ctrl

Overview:
Sequencing controller for the team's 2-bit magnitude comparator slice. It resolves wide-operand comparisons by stepping one shared 2-bit digit compare per cycle, MSB digit first, with optional early exit on the first unequal digit. It sits between a valid/ready operand source and a valid/ready result sink. The 2-bit slice compare (gt/eq/lt of one digit pair) is implemented inside the block.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2; DIGITS = WIDTH/2
EARLY_EXIT, 1, 1 = finish on first unequal digit; 0 = always examine all DIGITS

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; low freezes all state
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept an operand pair
out_valid  out  1  result valid
out_ready  in  1  sink accepts result
a_gt_b  out  1  result A > B
a_eq_b  out  1  result A == B
a_lt_b  out  1  result A < B
digits_used  out  clog2(DIGITS+1)  number of digit compares performed for the current result

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values: state IDLE, in_ready=1, out_valid=0, a_gt_b=a_eq_b=a_lt_b=0, digits_used=0, operand registers 0, digit index = DIGITS-1.
- ena=0: no state, register or output changes; in_ready and out_valid are forced to 0, so no handshake can complete.
- States: IDLE, COMPARE, RESULT.
- IDLE: in_ready=1. On in_valid && in_ready && ena:
  - latch in_a, in_b
  - idx <= DIGITS-1, digits_used <= 0, clear decided flag and result bits
  - go to COMPARE
- COMPARE (in_ready=0, out_valid=0), each enabled cycle:
  - compare digit d = A[2*idx+1:2*idx] vs B[2*idx+1:2*idx]; digits_used increments by 1.
  - If not yet decided and the digits are unequal: record gt or lt and set decided.
  - If EARLY_EXIT=1 and the digits are unequal: go to RESULT.
  - Else if idx == 0: go to RESULT; if still undecided, result is eq.
  - Else idx decrements.
- Result bits are exactly one-hot once out_valid=1; all 0 while out_valid=0.
- Latency: out_valid rises k cycles after the accept edge.
  - k = position of the first unequal digit counted from the MSB (1..DIGITS) with EARLY_EXIT=1.
  - k = DIGITS with EARLY_EXIT=0 or when A==B.
- RESULT: out_valid=1, results and digits_used held stable.
  - On out_ready && ena: go to IDLE; out_valid <= 0; result bits cleared; digits_used held until the next accept.
- No bypass: a new pair is accepted no earlier than the cycle after the result handshake. Throughput is at most one compare per k+2 cycles.
- in_valid while not in IDLE is ignored; the operand registers do not change.
- Reset asserted mid-COMPARE or in RESULT: immediate return to reset values; the in-flight result is discarded.
- WIDTH=2: single-digit compare, k=1 always.

Test Plan:
- WIDTH=8, EARLY_EXIT=1; A=0xC0, B=0x40, out_ready=1 -> first digit 3 vs 1; out_valid 1 cycle after accept; a_gt_b=1, digits_used=1.
- A=0x12, B=0x13 -> digits differ only at idx0; out_valid 4 cycles after accept; a_lt_b=1, digits_used=4. A=0xB4, B=0xB4 -> a_eq_b=1, digits_used=4.
- EARLY_EXIT=0; A=0xC0, B=0x40 -> a_gt_b=1, but out_valid only after 4 cycles, digits_used=4.
- Backpressure: A=0x01, B=0x00 with out_ready=0 for 3 cycles after out_valid -> a_gt_b, out_valid and digits_used held; in_ready=0. A new pair A=0x00, B=0xFF presented meanwhile is ignored. When out_ready=1, one cycle later in_ready=1 and the next accepted pair gives a_lt_b=1.
- Freeze and reset: in COMPARE with A=0x12, B=0x13:
  - ena=0 for 2 cycles -> idx and digits_used frozen; latency extends by 2.
  - Separate run: rst_n pulsed low during COMPARE -> outputs immediately return to reset values; the next pair completes normally.
- Exhaustive sweep with WIDTH=2 over all 16 (A,B) pairs 0..3 -> exactly one of gt/eq/lt matches the integer comparison, k=1 each.
